// File: rtl/motion_pkg.sv
// Shared widths, limits and FSM encoding for the motion_cntrl steering stage.
// MOTION_DERIV_EN adds the D_CALC state to the enum.
package motion_pkg;

   localparam int ERR_W = 12;
   localparam int DRV_W = 11;
   localparam int INT_W = 16;
   localparam int ES_W  = 10;
   localparam int P_W   = 14;
   localparam int D_W   = 15;
   localparam int PI_W  = 17;

   localparam int ERR_MAX = 511;
   localparam int ERR_MIN = -512;
   localparam int DRV_MAX = 1023;
   localparam int DRV_MIN = -1023;
   localparam int INT_MAX = 32767;
   localparam int INT_MIN = -32768;

   typedef enum logic [2:0] {
      IDLE,
      P_CALC,
      I_CALC,
`ifdef MOTION_DERIV_EN
      D_CALC,
`endif
      SUM,
      OUT
   } state_e;

endpackage

// File: rtl/motion_cntrl_if.sv
// Sample/command bundle between the line sensor front end, motion_cntrl and motor_cntrl.
// master drives the sample side; slave is the steering stage.
interface motion_cntrl_if;
   import motion_pkg::*;

   logic                    go;
   logic signed [DRV_W-1:0] fwd_spd;
   logic signed [ERR_W-1:0] error;
   logic                    err_vld;
   logic signed [DRV_W-1:0] lft;
   logic signed [DRV_W-1:0] rht;
   logic                    out_vld;
   logic                    busy;

   modport master (
      output go, fwd_spd, error, err_vld,
      input  lft, rht, out_vld, busy
   );

   modport slave (
      input  go, fwd_spd, error, err_vld,
      output lft, rht, out_vld, busy
   );

endinterface

// File: rtl/sat_clip.sv
// Signed saturating narrower: clips din into [MIN_V, MAX_V] and truncates to OUT_W bits.
module sat_clip #(
   parameter int IN_W  = 18,
   parameter int OUT_W = 11,
   parameter int MIN_V = -1023,
   parameter int MAX_V = 1023
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout
);

   localparam logic signed [IN_W-1:0]  MAX_I = IN_W'(MAX_V);
   localparam logic signed [IN_W-1:0]  MIN_I = IN_W'(MIN_V);
   localparam logic signed [OUT_W-1:0] MAX_O = OUT_W'(MAX_V);
   localparam logic signed [OUT_W-1:0] MIN_O = OUT_W'(MIN_V);

   always_comb begin
      if (din > MAX_I) begin
         dout = MAX_O;
      end else if (din < MIN_I) begin
         dout = MIN_O;
      end else begin
         dout = din[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/motion_cntrl.sv
// motion_cntrl: multi-cycle PI steering stage producing held lft/rht drive words for motor_cntrl.
// Optional macro MOTION_DERIV_EN adds a derivative term and one extra D_CALC cycle.
module motion_cntrl
   import motion_pkg::*;
#(
   parameter int unsigned P_COEFF = 4,
   parameter int unsigned INT_DEC = 4,
   parameter int unsigned I_SHIFT = 4,
   parameter int unsigned D_COEFF = 2
) (
   input  logic          clk,
   input  logic          rst,
   motion_cntrl_if.slave mif
);

   localparam int SUM_W = PI_W + 1;
   localparam logic signed [P_W-1:0] P_K = P_W'(P_COEFF);

   if (P_COEFF > 15 || D_COEFF > 15) begin : g_bad_gain
      $error("motion_cntrl: P_COEFF and D_COEFF must fit in 4 bits");
   end
   if (INT_DEC == 0 || INT_DEC > 15) begin : g_bad_dec
      $error("motion_cntrl: INT_DEC must be in 1..15");
   end

   state_e                  state_q, state_d;
   logic signed [ES_W-1:0]  err_sat_c, err_sat_q, err_sat_d;
   logic signed [DRV_W-1:0] fwd_q, fwd_d;
   logic signed [P_W-1:0]   p_q, p_d;
   logic signed [INT_W:0]   integ_sum;
   logic signed [INT_W-1:0] integ_q, integ_d, integ_sat, integ_new;
   logic signed [INT_W-1:0] iterm_q, iterm_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    dec_hit;
   logic signed [PI_W-1:0]  pi_c;
   logic signed [SUM_W-1:0] lft_raw, rht_raw;
   logic signed [DRV_W-1:0] lft_sat, rht_sat;
   logic signed [DRV_W-1:0] lft_q, lft_d, rht_q, rht_d;
   logic                    out_vld_q, out_vld_d;

`ifdef MOTION_DERIV_EN
   localparam logic signed [D_W-1:0] D_K = D_W'(D_COEFF);
   logic signed [ES_W-1:0] prev_q, prev_d;
   logic signed [D_W-1:0]  dterm_q, dterm_d;
   assign pi_c = PI_W'(p_q) + PI_W'(iterm_q) + PI_W'(dterm_q);
`else
   assign pi_c = PI_W'(p_q) + PI_W'(iterm_q);
`endif

   sat_clip #(.IN_W(ERR_W), .OUT_W(ES_W), .MIN_V(ERR_MIN), .MAX_V(ERR_MAX))
      u_err_sat (.din(mif.error), .dout(err_sat_c));

   // Integrator accumulates one bit wider so the clamp sees the true sum.
   assign integ_sum = (INT_W+1)'(integ_q) + (INT_W+1)'(err_sat_q);
   sat_clip #(.IN_W(INT_W+1), .OUT_W(INT_W), .MIN_V(INT_MIN), .MAX_V(INT_MAX))
      u_int_sat (.din(integ_sum), .dout(integ_sat));

   assign dec_hit   = (cnt_q == 4'(INT_DEC - 1));
   assign integ_new = dec_hit ? integ_sat : integ_q;

   assign lft_raw = SUM_W'(fwd_q) - SUM_W'(pi_c);
   assign rht_raw = SUM_W'(fwd_q) + SUM_W'(pi_c);
   sat_clip #(.IN_W(SUM_W), .OUT_W(DRV_W), .MIN_V(DRV_MIN), .MAX_V(DRV_MAX))
      u_lft_sat (.din(lft_raw), .dout(lft_sat));
   sat_clip #(.IN_W(SUM_W), .OUT_W(DRV_W), .MIN_V(DRV_MIN), .MAX_V(DRV_MAX))
      u_rht_sat (.din(rht_raw), .dout(rht_sat));

   always_comb begin
      state_d   = state_q;
      err_sat_d = err_sat_q;
      fwd_d     = fwd_q;
      p_d       = p_q;
      integ_d   = integ_q;
      iterm_d   = iterm_q;
      cnt_d     = cnt_q;
      lft_d     = lft_q;
      rht_d     = rht_q;
      out_vld_d = 1'b0;
`ifdef MOTION_DERIV_EN
      prev_d    = prev_q;
      dterm_d   = dterm_q;
`endif
      if (!mif.go) begin
         // Losing go drops any sample in flight and returns the loop to a cold start.
         state_d = IDLE;
         lft_d   = '0;
         rht_d   = '0;
         integ_d = '0;
         cnt_d   = '0;
`ifdef MOTION_DERIV_EN
         prev_d  = '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (mif.err_vld) begin
                  err_sat_d = err_sat_c;
                  fwd_d     = mif.fwd_spd;
                  state_d   = P_CALC;
               end
            end
            P_CALC: begin
               p_d     = P_W'(err_sat_q) * P_K;
               state_d = I_CALC;
            end
            I_CALC: begin
               integ_d = integ_new;
               cnt_d   = dec_hit ? 4'd0 : cnt_q + 4'd1;
               iterm_d = integ_new >>> I_SHIFT;
`ifdef MOTION_DERIV_EN
               state_d = D_CALC;
`else
               state_d = SUM;
`endif
            end
`ifdef MOTION_DERIV_EN
            D_CALC: begin
               dterm_d = (D_W'(err_sat_q) - D_W'(prev_q)) * D_K;
               prev_d  = err_sat_q;
               state_d = SUM;
            end
`endif
            SUM: begin
               // Drive words land here so they are already valid while OUT pulses out_vld.
               lft_d     = lft_sat;
               rht_d     = rht_sat;
               out_vld_d = 1'b1;
               state_d   = OUT;
            end
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         lft_q     <= '0;
         rht_q     <= '0;
         out_vld_q <= 1'b0;
         integ_q   <= '0;
         cnt_q     <= '0;
`ifdef MOTION_DERIV_EN
         prev_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         lft_q     <= lft_d;
         rht_q     <= rht_d;
         out_vld_q <= out_vld_d;
         integ_q   <= integ_d;
         cnt_q     <= cnt_d;
`ifdef MOTION_DERIV_EN
         prev_q    <= prev_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      err_sat_q <= err_sat_d;
      fwd_q     <= fwd_d;
      p_q       <= p_d;
      iterm_q   <= iterm_d;
`ifdef MOTION_DERIV_EN
      dterm_q   <= dterm_d;
`endif
   end

   assign mif.lft     = lft_q;
   assign mif.rht     = rht_q;
   assign mif.out_vld = out_vld_q;
   assign mif.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_motion_cntrl.sv
// Bench for motion_cntrl: two instances (INT_DEC=1 and INT_DEC=4) share one stimulus stream
// and are compared every cycle against a transaction-level PI model; directed cases pin the model.
module tb_motion_cntrl;
   import motion_pkg::*;

   localparam int P_K = 4;
   localparam int ISH = 4;
   localparam int D_K = 2;
`ifdef MOTION_DERIV_EN
   localparam int LAT   = 5;
   localparam bit DERIV = 1'b1;
`else
   localparam int LAT   = 4;
   localparam bit DERIV = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic go;
   logic err_vld;
   logic signed [ERR_W-1:0] err;
   logic signed [DRV_W-1:0] fwd;
   bit   chk_en = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   motion_cntrl_if if1 ();
   motion_cntrl_if if4 ();

   assign if1.go = go;  assign if1.err_vld = err_vld;  assign if1.error = err;  assign if1.fwd_spd = fwd;
   assign if4.go = go;  assign if4.err_vld = err_vld;  assign if4.error = err;  assign if4.fwd_spd = fwd;

   motion_cntrl #(.P_COEFF(4), .INT_DEC(1), .I_SHIFT(4), .D_COEFF(2))
      u_dut1 (.clk(clk), .rst(rst), .mif(if1));
   motion_cntrl #(.P_COEFF(4), .INT_DEC(4), .I_SHIFT(4), .D_COEFF(2))
      u_dut4 (.clk(clk), .rst(rst), .mif(if4));

   // ---------------- reference model (transaction level) ----------------
   int m_int [2];
   int m_cnt [2];
   int m_prev[2];
   int m_busy[2];
   int m_lft [2];
   int m_rht [2];
   int m_plft[2];
   int m_prht[2];
   bit m_vld [2];

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   function automatic void model_clear(input int k, input bit full);
      m_int[k] = 0; m_cnt[k] = 0; m_prev[k] = 0; m_busy[k] = 0;
      m_lft[k] = 0; m_rht[k] = 0; m_vld[k] = 1'b0;
      if (full) begin m_plft[k] = 0; m_prht[k] = 0; end
   endfunction

   function automatic void model_accept(input int k, input int e, input int f);
      int dec, es, p, i, d, pi;
      dec = (k == 0) ? 1 : 4;
      es  = clampi(e, -512, 511);
      p   = es * P_K;
      if (m_cnt[k] == dec - 1) begin
         m_int[k] = clampi(m_int[k] + es, -32768, 32767);
         m_cnt[k] = 0;
      end else begin
         m_cnt[k] = m_cnt[k] + 1;
      end
      i  = m_int[k] >>> ISH;
      d  = DERIV ? (es - m_prev[k]) * D_K : 0;
      m_prev[k] = es;
      pi = p + i + d;
      m_plft[k] = clampi(f - pi, -1023, 1023);
      m_prht[k] = clampi(f + pi, -1023, 1023);
      m_busy[k] = LAT;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst || !go) begin
            model_clear(k, rst);
         end else begin
            m_vld[k] = 1'b0;
            if (m_busy[k] == 0) begin
               if (err_vld) model_accept(k, int'(err), int'(fwd));
            end else begin
               m_busy[k] = m_busy[k] - 1;
               if (m_busy[k] == 1) begin
                  m_lft[k] = m_plft[k];
                  m_rht[k] = m_prht[k];
                  m_vld[k] = 1'b1;
               end
            end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("dut1_lft",  int'(if1.lft),     m_lft[0]);
         chk("dut1_rht",  int'(if1.rht),     m_rht[0]);
         chk("dut1_vld",  int'(if1.out_vld), int'(m_vld[0]));
         chk("dut1_busy", int'(if1.busy),    int'(m_busy[0] > 0));
         chk("dut4_lft",  int'(if4.lft),     m_lft[1]);
         chk("dut4_rht",  int'(if4.rht),     m_rht[1]);
         chk("dut4_vld",  int'(if4.out_vld), int'(m_vld[1]));
         chk("dut4_busy", int'(if4.busy),    int'(m_busy[1] > 0));
      end
   end

   // ---------------- stimulus ----------------
   int cap_l1, cap_r1, cap_l4, cap_r4;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; err_vld = 1'b0; go = 1'b1;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic send(input int e, input int f);
      bit seen;
      err_vld = 1'b1; err = 12'(e); fwd = 11'(f);
      tick();
      err_vld = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         tick();
         if (if1.out_vld) seen = 1'b1;
      end
      if (!seen) chk("out_vld_timeout", 0, 1);
      cap_l1 = int'(if1.lft); cap_r1 = int'(if1.rht);
      cap_l4 = int'(if4.lft); cap_r4 = int'(if4.rht);
      tick();
   endtask

   initial begin
      int mode, t;
      bit bias;
      rst = 1'b1; go = 1'b1; err_vld = 1'b0; err = '0; fwd = '0;
      tick(); tick();
      chk_en = 1'b1;
      chk("reset_lft", int'(if1.lft), 0);
      chk("reset_rht", int'(if1.rht), 0);
      chk("reset_vld", int'(if1.out_vld), 0);
      chk("reset_busy", int'(if1.busy), 0);
      rst = 1'b0;

      // Nominal: error=0 then error=100 at fwd 300.
      send(0, 300);
      send(100, 300);
      chk("nominal_lft", cap_l1, DERIV ? -306 : -106);
      chk("nominal_rht", cap_r1, DERIV ?  906 :  706);
      chk("nominal_dec4_lft", cap_l4, DERIV ? -300 : -100);

      // Output saturation.
      do_reset();
      send(2047, 0);
      chk("sat_lft", cap_l1, -1023);
      chk("sat_rht", cap_r1,  1023);

      // Integrator clamp.
      do_reset();
      for (int s = 1; s <= 70; s++) begin
         send(511, 0);
         if (s == 64) chk("int_at_64", int'(u_dut1.integ_q), 32704);
         if (s == 65) chk("int_at_65", int'(u_dut1.integ_q), 32767);
         if (s == 70) chk("int_at_70", int'(u_dut1.integ_q), 32767);
      end

      // Decimation with INT_DEC=4.
      do_reset();
      for (int s = 1; s <= 8; s++) begin
         send(16, 0);
         if (s == 3) chk("dec_int_at_3", int'(u_dut4.integ_q), 0);
         if (s == 4) begin
            chk("dec_int_at_4", int'(u_dut4.integ_q), 16);
            chk("dec_lft_at_4", cap_l4, -65);
         end
         if (s == 8) begin
            chk("dec_int_at_8", int'(u_dut4.integ_q), 32);
            chk("dec_rht_at_8", cap_r4, 66);
         end
      end

      // Busy strobe ignored, then abort with go low.
      do_reset();
      send(100, 300);
      err_vld = 1'b1; err = 12'sd50;
      tick();
      err_vld = 1'b0;
      chk("abort_vld_n1", int'(if1.out_vld), 0);
      tick();
      err_vld = 1'b1;
      chk("abort_vld_n2", int'(if1.out_vld), 0);
      tick();
      err_vld = 1'b0; go = 1'b0;
      chk("abort_vld_n3", int'(if1.out_vld), 0);
      tick();
      chk("abort_vld_n4", int'(if1.out_vld), 0);
      chk("abort_lft", int'(if1.lft), 0);
      chk("abort_rht", int'(if1.rht), 0);
      chk("abort_busy", int'(if1.busy), 0);
      chk("abort_int", int'(u_dut1.integ_q), 0);
      go = 1'b1;
      tick();

      // Randomized traffic.
      bias = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         rst     = ($urandom_range(0, 399) == 0);
         go      = ($urandom_range(0, 59) != 0);
         err_vld = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 99) == 0) bias = ~bias;
         mode = $urandom_range(0, 3);
         case (mode)
            0:       err = 12'($urandom);
            1:       begin t = $urandom_range(0, 128) - 64; err = 12'(t); end
            2:       err = bias ? 12'sd2047 : -12'sd2048;
            default: err = bias ? 12'sd511 : -12'sd512;
         endcase
         if (m_busy[0] == 0 && m_busy[1] == 0) fwd = 11'($urandom);
         tick();
      end
      rst = 1'b0; go = 1'b1; err_vld = 1'b0;
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
